// File: rtl/lag_signal_generator.sv
// Pseudo-random far-end sample source with a fixed-lag echo copy.
// A 16-bit Fibonacci LFSR feeds a LAG-deep delay line; everything advances only when enabled.
module lag_signal_generator #(
    parameter int              WIDTH = 16,
    parameter int              LAG   = 4,
    parameter logic [15:0]     SEED  = 16'hACE1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_signal_random,
    output logic [WIDTH-1:0] o_signal_lag,
    output logic             o_lag_valid
);

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [15:0] RESET_STATE = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam int          CW          = $clog2(LAG + 1);
    localparam logic [CW-1:0] FULL      = CW'(LAG);
    localparam logic [CW-1:0] ALMOST    = CW'(LAG - 1);

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_delay [LAG];
    logic [CW-1:0]    r_count;
    logic             r_valid;
    logic             w_fb;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr  <= RESET_STATE;
            for (int k = 0; k < LAG; k++) begin
                r_delay[k] <= '0;
            end
            r_count <= '0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_lfsr <= (r_lfsr == '0) ? 16'h0001 : {r_lfsr[14:0], w_fb};
            r_delay[0] <= r_lfsr;
            for (int k = 1; k < LAG; k++) begin
                r_delay[k] <= r_delay[k-1];
            end
            // Valid goes high on the edge that brings the fill count to LAG and then sticks.
            if (r_count != FULL) begin
                r_count <= r_count + CW'(1);
            end
            r_valid <= (r_count >= ALMOST);
        end
    end

    assign o_signal_random = r_lfsr;
    assign o_signal_lag    = r_delay[LAG-1];
    assign o_lag_valid     = r_valid;

endmodule

// File: tb/tb_lag_signal_generator.sv
// Self-checking bench for lag_signal_generator: software LFSR model plus a
// scoreboard queue of emitted samples that is popped to predict the lagged output.
module tb_lag_signal_generator;

    localparam int LAG = 4;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] sigRandom;
    logic [15:0] sigLag;
    logic        lagValid;
    logic [15:0] sigRandom0;
    logic [15:0] sigLag0;
    logic        lagValid0;

    int checks;
    int errors;

    logic [15:0] modelQ;
    int          modelCount;
    logic [15:0] sbQ[$];
    logic [15:0] expRandom;
    logic [15:0] expLag;
    logic        expValid;

    lag_signal_generator #(.WIDTH(16), .LAG(LAG), .SEED(16'hACE1)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_en            (en),
        .o_signal_random (sigRandom),
        .o_signal_lag    (sigLag),
        .o_lag_valid     (lagValid)
    );

    lag_signal_generator #(.WIDTH(16), .LAG(LAG), .SEED(16'h0000)) dutZero (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_en            (en),
        .o_signal_random (sigRandom0),
        .o_signal_lag    (sigLag0),
        .o_lag_valid     (lagValid0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsrNext(input logic [15:0] q);
        logic fb;
        fb = q[15] ^ q[13] ^ q[12] ^ q[10];
        return {q[14:0], fb};
    endfunction

    // Drive one edge, then advance the model and scoreboard to predict the DUT after it.
    task automatic tick(input logic rstVal, input logic enVal);
        rst = rstVal;
        en  = enVal;
        @(posedge clk);
        #1;
        if (rstVal) begin
            modelQ     = 16'hACE1;
            modelCount = 0;
            sbQ.delete();
        end else if (enVal) begin
            sbQ.push_back(modelQ);
            if (sbQ.size() > LAG) void'(sbQ.pop_front());
            modelQ = lfsrNext(modelQ);
            if (modelCount < LAG) modelCount++;
        end
        expRandom = modelQ;
        expLag    = (sbQ.size() == LAG) ? sbQ[0] : 16'h0000;
        expValid  = (modelCount == LAG);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0);
        checks++;
        if (sigRandom !== 16'hACE1) begin
            errors++;
            $display("[TB] FAIL reset_random got %h expected %h", sigRandom, 16'hACE1);
        end
        checks++;
        if (sigLag !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_lag got %h expected %h", sigLag, 16'h0000);
        end
        checks++;
        if (lagValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid got %b expected 0", lagValid);
        end
        checks++;
        if (sigRandom0 !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL seed0_reset got %h expected %h", sigRandom0, 16'h0001);
        end
    endtask

    task automatic test_first_steps();
        tick(1'b0, 1'b1);
        checks++;
        if (sigRandom !== 16'h59C3) begin
            errors++;
            $display("[TB] FAIL step1_random got %h expected %h", sigRandom, 16'h59C3);
        end
        checks++;
        if (sigRandom0 !== 16'h0002) begin
            errors++;
            $display("[TB] FAIL seed0_step1 got %h expected %h", sigRandom0, 16'h0002);
        end
        tick(1'b0, 1'b1);
        checks++;
        if (sigRandom !== 16'hB387) begin
            errors++;
            $display("[TB] FAIL step2_random got %h expected %h", sigRandom, 16'hB387);
        end
    endtask

    // Assumes the bench is freshly reset; checks the fill ramp over the first five edges.
    task automatic test_fill(input string tag);
        for (int n = 1; n <= LAG + 1; n++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (lagValid !== (n >= LAG)) begin
                errors++;
                $display("[TB] FAIL %s_valid edge %0d got %b expected %b", tag, n, lagValid, (n >= LAG));
            end
            checks++;
            if (sigLag !== expLag) begin
                errors++;
                $display("[TB] FAIL %s_lag edge %0d got %h expected %h", tag, n, sigLag, expLag);
            end
        end
        checks++;
        if (sigLag !== 16'h59C3) begin
            errors++;
            $display("[TB] FAIL %s_lag_edge5 got %h expected %h", tag, sigLag, 16'h59C3);
        end
    endtask

    task automatic test_long_run();
        int bad;
        bad = 0;
        for (int n = 0; n < 2000; n++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (sigRandom !== expRandom || sigLag !== expLag || lagValid !== expValid
                || sigRandom === 16'h0000) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("[TB] FAIL long_run sample %0d got %h/%h/%b expected %h/%h/%b",
                             n, sigRandom, sigLag, lagValid, expRandom, expLag, expValid);
            end
        end
    endtask

    task automatic test_random_enable();
        logic [15:0] prevRandom;
        logic [15:0] prevLag;
        logic        prevValid;
        logic        enVal;
        int bad;
        bad = 0;
        for (int n = 0; n < 400; n++) begin
            prevRandom = sigRandom;
            prevLag    = sigLag;
            prevValid  = lagValid;
            enVal      = 1'($urandom_range(0, 1));
            tick(1'b0, enVal);
            checks++;
            if (sigRandom !== expRandom || sigLag !== expLag || lagValid !== expValid
                || (!enVal && (sigRandom !== prevRandom || sigLag !== prevLag || lagValid !== prevValid))) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("[TB] FAIL random_en step %0d en %b got %h/%h/%b expected %h/%h/%b",
                             n, enVal, sigRandom, sigLag, lagValid, expRandom, expLag, expValid);
            end
        end
    endtask

    task automatic test_mid_reset();
        tick(1'b1, 1'b1);
        checks++;
        if (sigRandom !== 16'hACE1 || sigLag !== 16'h0000 || lagValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset got %h/%h/%b expected ace1/0000/0",
                     sigRandom, sigLag, lagValid);
        end
        test_fill("refill");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        en     = 1'b0;
        modelQ = 16'hACE1;
        modelCount = 0;
        test_reset();
        test_first_steps();
        test_reset();
        test_fill("fill");
        test_long_run();
        test_random_enable();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
